// File: rtl/tick_dpad_debounce.sv
// Debounces four direction buttons on a tick timebase and emits auto-repeating
// move commands over a valid/ready handshake with single-slot overflow drop.
module tick_dpad_debounce #(
  parameter int unsigned DEB_TICKS  = 2,
  parameter int unsigned HOLD_TICKS = 5,
  parameter int unsigned REP_TICKS  = 2,
  parameter bit          REP_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic [3:0] btn_in,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       move_drop,
  output logic       pressed
);

  typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_REPEAT, S_LOCK} state_e;

  localparam logic [7:0] DEB_T  = 8'(DEB_TICKS);
  localparam logic [7:0] HOLD_T = 8'(HOLD_TICKS);
  localparam logic [7:0] REP_T  = 8'(REP_TICKS);

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [3:0] sync1_q, s_q;
  state_e     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d, hcnt_q, hcnt_d, rcnt_q, rcnt_d;
  logic       valid_q, valid_d, drop_q, drop_d;
  logic [1:0] dir_q, dir_d;
  logic       issue;

  function automatic logic [1:0] pri(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    rcnt_d  = rcnt_q;
    issue   = 1'b0;
    if (tick_in) begin
      case (state_q)
        S_IDLE: begin
          if (s_q != 4'd0) begin
            cand_d = pri(s_q);
            cnt_d  = 8'd1;
            if (DEB_TICKS == 1) begin
              issue   = 1'b1;
              cnt_d   = 8'd0;
              hcnt_d  = 8'd0;
              state_d = S_HELD;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (!s_q[cand_q]) begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else if (cnt_q + 8'd1 == DEB_T) begin
            issue   = 1'b1;
            cnt_d   = 8'd0;
            hcnt_d  = 8'd0;
            state_d = S_HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_HELD: begin
          if (s_q == 4'd0) begin
            hcnt_d  = 8'd0;
            state_d = S_IDLE;
          end else if (!s_q[cand_q]) begin
            hcnt_d  = 8'd0;
            state_d = S_LOCK;
          end else if (REP_EN && (hcnt_q + 8'd1 == HOLD_T)) begin
            issue   = 1'b1;
            hcnt_d  = 8'd0;
            rcnt_d  = 8'd0;
            state_d = S_REPEAT;
          end else if (hcnt_q != 8'hFF) begin
            // saturates when repeat is disabled so the count never wraps
            hcnt_d = hcnt_q + 8'd1;
          end
        end
        S_REPEAT: begin
          if (s_q == 4'd0) begin
            rcnt_d  = 8'd0;
            state_d = S_IDLE;
          end else if (!s_q[cand_q]) begin
            rcnt_d  = 8'd0;
            state_d = S_LOCK;
          end else if (rcnt_q + 8'd1 == REP_T) begin
            issue  = 1'b1;
            rcnt_d = 8'd0;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end
        S_LOCK: begin
          if (s_q == 4'd0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A new move may overwrite the slot only when it is empty or being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    drop_d  = 1'b0;
    if (valid_q && move_ready) valid_d = 1'b0;
    if (issue) begin
      if (!valid_q || move_ready) begin
        valid_d = 1'b1;
        dir_d   = cand_d;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q <= 4'd0;
      s_q     <= 4'd0;
      state_q <= S_IDLE;
      cand_q  <= 2'd0;
      cnt_q   <= 8'd0;
      hcnt_q  <= 8'd0;
      rcnt_q  <= 8'd0;
      valid_q <= 1'b0;
      dir_q   <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      s_q     <= sync1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      drop_q  <= drop_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign move_drop  = drop_q;
  assign pressed    = (state_q == S_HELD) || (state_q == S_REPEAT);

endmodule
